// File: rtl/asfifo_stereo_unpacker.sv
// Read-side consumer of the async audio FIFO: pairs 16-bit words into {left, right}
// stereo samples on a valid/ready stream and counts sink underruns.
module asfifo_stereo_unpacker #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  sync_clr,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_left,
    output logic [DATA_WIDTH-1:0] m_right,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  underrun_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] buf_mem [4];
    logic [1:0]            head_reg, head_next, tail;
    logic [2:0]            count_reg, count_next, count_after_pop;
    logic                  inflight_reg;
    logic                  load, push, handshake;

    always_comb begin
        load            = (count_reg >= 3'd2) && (!m_valid || m_ready) && !sync_clr;
        count_after_pop = load ? (count_reg - 3'd2) : count_reg;
        // Reserve a slot for every word already requested so the buffer cannot overflow.
        fifo_rd_en      = enable && !sync_clr && !fifo_rd_empty &&
                          ((count_after_pop + {2'b00, inflight_reg}) <= 3'd3);
        push            = inflight_reg && !sync_clr;
        tail            = head_reg + count_reg[1:0];
        handshake       = m_valid && m_ready;
        underrun        = (state_reg == RUN) && m_ready && !m_valid && !sync_clr;

        if (sync_clr) begin
            count_next = 3'd0;
            head_next  = 2'd0;
        end else begin
            count_next = count_after_pop + {2'b00, push};
            head_next  = load ? (head_reg + 2'd2) : head_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = PRIME;
            PRIME:   if (!enable) state_next = IDLE;
                     else if (handshake) state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (sync_clr) state_next = enable ? PRIME : IDLE;
    end

    always_ff @(posedge rd_clk) begin
        if (push) buf_mem[tail] <= fifo_rd_data;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_reg    <= IDLE;
            head_reg     <= 2'd0;
            count_reg    <= 3'd0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            count_reg    <= count_next;
            inflight_reg <= fifo_rd_en;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            m_valid <= 1'b0;
            m_left  <= '0;
            m_right <= '0;
        end else if (sync_clr) begin
            m_valid <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_left  <= buf_mem[head_reg];
            m_right <= buf_mem[head_reg + 2'd1];
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            underrun_cnt <= '0;
        end else if (underrun && !(&underrun_cnt)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_asfifo_stereo_unpacker.sv
// Bench for asfifo_stereo_unpacker: FIFO model with 1-cycle read latency, word-stream
// scoreboard for pairing, and a rule-level model of underrun counting.
module tb_asfifo_stereo_unpacker;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, enable, sync_clr, fifo_rd_en, fifo_empty, m_valid, m_ready, underrun;
    logic [DW-1:0] fifo_data, m_left, m_right;
    logic [CW-1:0] underrun_cnt;

    always #5 clk = ~clk;

    asfifo_stereo_unpacker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rd_clk(clk), .rd_rst(rst), .enable(enable), .sync_clr(sync_clr),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_data), .fifo_rd_empty(fifo_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_left(m_left), .m_right(m_right),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    int            checks = 0, errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_words[$];
    int            reads, hs_count, pulses, cycle, first_hs, last_hs, exp_cnt;
    bit            do_pop, running, armed, prev_hold;
    logic [DW-1:0] prev_l, prev_r, hs_l, hs_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        exp_words.delete();
        running   = 0;
        armed     = 0;
        exp_cnt   = 0;
        prev_hold = 0;
    endtask

    // Evaluated at the falling edge, when all DUT inputs and outputs are settled.
    task automatic monitor();
        bit hs, exp_ur;
        logic [DW-1:0] l, r;
        cycle++;
        do_pop = 0;
        if (rst) begin
            reset_model();
            return;
        end
        if (fifo_rd_en) begin
            chk("rd_while_empty", fifo_empty, 1'b0);
            chk("rd_gated", enable & ~sync_clr, 1'b1);
        end
        if (prev_hold) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", {m_left, m_right}, {prev_l, prev_r});
        end
        hs = m_valid & m_ready;
        if (hs) begin
            if (exp_words.size() < 2) begin
                chk("pair_avail", exp_words.size(), 2);
            end else begin
                l = exp_words.pop_front();
                r = exp_words.pop_front();
                chk("pair", {m_left, m_right}, {l, r});
            end
            if (hs_count == 0) first_hs = cycle;
            last_hs = cycle;
            hs_l = m_left;
            hs_r = m_right;
            hs_count++;
        end
        exp_ur = running & m_ready & ~m_valid & ~sync_clr;
        chk("underrun", underrun, exp_ur);
        if (underrun) pulses++;
        chk("underrun_cnt", underrun_cnt, exp_cnt);
        if (exp_ur && exp_cnt < CNT_MAX) exp_cnt++;
        prev_hold = m_valid & ~m_ready & ~sync_clr;
        prev_l    = m_left;
        prev_r    = m_right;
        if (sync_clr) exp_words.delete();
        running = enable & ~sync_clr & (running | (armed & hs));
        armed   = enable;
        do_pop  = fifo_rd_en;
    endtask

    task automatic tick();
        logic [DW-1:0] w;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (do_pop && !rst && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            fifo_data = w;
            exp_words.push_back(w);
            reads++;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; sync_clr = 1'b0; m_ready = 1'b0;
        fifo_q.delete(); fifo_empty = 1'b1; fifo_data = '0;
        tick(); tick();
        rst = 1'b0;
        reads = 0; hs_count = 0; pulses = 0;
    endtask

    task automatic wait_hs(input string tag, input int n, input int budget);
        int k = 0;
        while (hs_count < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, hs_count >= n, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        chk({tag, "_valid"}, m_valid, 1'b0);
        chk({tag, "_left"}, m_left, '0);
        chk({tag, "_right"}, m_right, '0);
        chk({tag, "_underrun"}, underrun, 1'b0);
        chk({tag, "_cnt"}, underrun_cnt, '0);
    endtask

    initial begin
        int k;
        rst = 1'b1; enable = 1'b0; sync_clr = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data = '0;
        reads = 0; hs_count = 0; pulses = 0; cycle = 0;
        reset_model();
        #2;
        check_zero_outputs("reset");
        do_reset();

        // T1 pairing with a free-running sink
        for (int i = 1; i <= 8; i++) push(DW'(i));
        enable = 1'b1; m_ready = 1'b1;
        wait_hs("t1_timeout", 4, 30);
        chk("t1_span", (last_hs - first_hs) <= 6, 1'b1);
        chk("t1_reads", reads, 8);
        chk("t1_left_over", exp_words.size(), 0);

        // T2 backpressure
        do_reset();
        for (int i = 0; i < 8; i++) push(DW'(16'h0100 + i));
        enable = 1'b1;
        repeat (20) tick();
        chk("t2_reads_le6", reads <= 6, 1'b1);
        chk("t2_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        wait_hs("t2_timeout", 4, 30);
        chk("t2_reads", reads, 8);
        chk("t2_left_over", exp_words.size(), 0);

        // T3 underrun counting and saturation
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        push(16'h0021); push(16'h0022);
        wait_hs("t3_timeout", 1, 20);
        pulses = 0;
        repeat (10) tick();
        chk("t3_cnt10", underrun_cnt, 10);
        chk("t3_pulses10", pulses, 10);
        repeat (10) tick();
        chk("t3_cnt_sat", underrun_cnt, CNT_MAX);
        chk("t3_pulses20", pulses, 20);

        // T4 flush with a read in flight
        do_reset();
        for (int i = 0; i < 8; i++) push(DW'(16'h000A + i));
        enable = 1'b1;
        k = 0;
        while (reads < 4 && k < 20) begin tick(); k++; end
        chk("t4_reads", reads, 4);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0; m_ready = 1'b1; hs_count = 0;
        wait_hs("t4_timeout", 1, 20);
        chk("t4_first_pair", {hs_l, hs_r}, {16'h000E, 16'h000F});

        // T5 enable drops after three reads
        do_reset();
        for (int i = 0; i < 8; i++) push(DW'(16'h0051 + i));
        enable = 1'b1; m_ready = 1'b1;
        k = 0;
        while (reads < 3 && k < 20) begin tick(); k++; end
        enable = 1'b0;
        repeat (20) tick();
        chk("t5_reads", reads, 3);
        chk("t5_pairs", hs_count, 1);
        chk("t5_cnt", underrun_cnt, 0);
        chk("t5_valid", m_valid, 1'b0);
        chk("t5_partial", exp_words.size(), 1);
        chk("t5_rd_en", fifo_rd_en, 1'b0);

        // T6 asynchronous reset while a sample is held
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        push(16'h0061); push(16'h0062);
        wait_hs("t6_timeout", 1, 20);
        repeat (5) tick();
        m_ready = 1'b0;
        push(16'h0063); push(16'h0064);
        k = 0;
        while (!m_valid && k < 20) begin tick(); k++; end
        chk("t6_cnt5", underrun_cnt, 5);
        chk("t6_valid", m_valid, 1'b1);
        #3;
        rst = 1'b1;
        fifo_q.delete(); fifo_empty = 1'b1; fifo_data = '0;
        #1;
        check_zero_outputs("t6_async");
        tick(); tick();
        rst = 1'b0; m_ready = 1'b1;
        repeat (5) tick();
        chk("t6_idle_cnt", underrun_cnt, 0);

        // Randomized traffic: sink stalls, enable gaps and occasional flushes
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 40) push(DW'($urandom));
            m_ready  = ($urandom_range(0, 3) != 0);
            enable   = ($urandom_range(0, 15) != 0);
            sync_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        sync_clr = 1'b0;
        chk("rand_pairs_seen", hs_count > 20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
